river_lane: RTL and testbench



---
 rtl/frogger_pkg.sv | 48 ++++
 rtl/lane_obj_collide.sv | 48 ++++
 rtl/river_lane.sv | 169 ++++++++++++++++
 tb/tb_river_lane.sv | 394 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/frogger_pkg.sv
// rtl/frogger_pkg.sv - shared types, constants and position helpers for the frogger lane logic
// Contents:
//   coord_t        11-bit screen coordinate
//   mover_state_t  WAIT / MOVE stepping states
//   dive_state_t   SURFACE / SINKING / SUBMERGED / RISING dive phases
//   step_pos       one wrapped step of an internal position in [0, span)
//   reset_pos      starting internal position of object idx
package frogger_pkg;

    typedef logic [10:0] coord_t;

    typedef enum logic {
        WAIT = 1'b0,
        MOVE = 1'b1
    } mover_state_t;

    typedef enum logic [1:0] {
        SURFACE   = 2'd0,
        SINKING   = 2'd1,
        SUBMERGED = 2'd2,
        RISING    = 2'd3
    } dive_state_t;

    localparam int SCREEN_W = 640;
    localparam int SCREEN_H = 480;

    // Positions live in [0, span); the sum needs one extra bit before the wrap compare.
    function automatic coord_t step_pos(input coord_t p, input logic dir,
                                        input coord_t step, input coord_t span);
        logic [11:0] w_sum;
        w_sum = {1'b0, p} + {1'b0, step};
        if (dir) begin
            if (w_sum >= {1'b0, span}) return coord_t'(w_sum - {1'b0, span});
            else                       return coord_t'(w_sum);
        end else begin
            if (p < step) return coord_t'(p + span - step);
            else          return coord_t'(p - step);
        end
    endfunction

    function automatic coord_t reset_pos(input coord_t start, input int idx, input int obj_w,
                                         input int spacing, input int span);
        int v;
        v = int'(start) + obj_w + idx * spacing;
        return coord_t'(v % span);
    endfunction

endpackage

// File: rtl/lane_obj_collide.sv
// rtl/lane_obj_collide.sv - four-corner frog overlap test against one lane object
// Ports:
//   i_obj_x    object visible X, two's complement
//   i_lane_y   lane top Y
//   i_frog_x   frog top-left X
//   i_frog_y   frog top-left Y
//   i_visible  object is solid; 0 forces no collision
//   o_collide  any inset frog corner lies inside the object box (inclusive)
module lane_obj_collide #(
    parameter int OBJ_W     = 40,
    parameter int OBJ_H     = 40,
    parameter int FROG_SIDE = 40,
    parameter int X_TOL     = 5,
    parameter int Y_TOL     = 1
) (
    input  logic [10:0] i_obj_x,
    input  logic [10:0] i_lane_y,
    input  logic [10:0] i_frog_x,
    input  logic [10:0] i_frog_y,
    input  logic        i_visible,
    output logic        o_collide
);

    logic signed [11:0] w_box_l, w_box_r, w_box_t, w_box_b;
    logic signed [11:0] w_cx_l, w_cx_r, w_cy_t, w_cy_b;
    logic               w_hit_x, w_hit_y;

    // Object X is already signed; frog and lane coordinates are unsigned and zero-extended.
    assign w_box_l = {i_obj_x[10], i_obj_x};
    assign w_box_r = w_box_l + $signed(12'(OBJ_W));
    assign w_box_t = $signed({1'b0, i_lane_y});
    assign w_box_b = w_box_t + $signed(12'(OBJ_H));

    assign w_cx_l = $signed({1'b0, i_frog_x}) + $signed(12'(X_TOL));
    assign w_cx_r = $signed({1'b0, i_frog_x}) + $signed(12'(FROG_SIDE - X_TOL));
    assign w_cy_t = $signed({1'b0, i_frog_y}) + $signed(12'(Y_TOL));
    assign w_cy_b = $signed({1'b0, i_frog_y}) + $signed(12'(FROG_SIDE - Y_TOL));

    // The four corners are the cross product of two X and two Y values, so
    // "any corner inside" factors into (either X inside) and (either Y inside).
    assign w_hit_x = ((w_cx_l >= w_box_l) && (w_cx_l <= w_box_r)) ||
                     ((w_cx_r >= w_box_l) && (w_cx_r <= w_box_r));
    assign w_hit_y = ((w_cy_t >= w_box_t) && (w_cy_t <= w_box_b)) ||
                     ((w_cy_b >= w_box_t) && (w_cy_b <= w_box_b));

    assign o_collide = i_visible && w_hit_x && w_hit_y;

endmodule

// File: rtl/river_lane.sv
// rtl/river_lane.sv - lane of NUM_OBJ objects stepping together with screen wrap, frog collision and carry
// Optional dive behaviour enabled by defining LANE_DIVE_EN (adds the Dive_State port).
// Ports:
//   frame_clk, Reset      frame clock, asynchronous active-high reset
//   Enable                1 = lane moves, 0 = frozen with tick counter held
//   Lane_Y, Start_X       lane top Y, visible X of object 0 at reset
//   Direction, Speed      0 = left / 1 = right, frames waited between steps
//   Frog_X, Frog_Y        frog top-left corner
//   Obj_X                 visible X of object i at [11i+10:11i], two's complement
//   Obj_Visible           object drawable/solid
//   Collision, On_Object  per-object frog overlap and its OR
//   Step_Pulse            high during the frame in which objects step
//   Carry_Dx              X delta the riding frog applies this frame
//   Dive_State            (LANE_DIVE_EN only) current dive phase 0..3
module river_lane #(
    parameter int NUM_OBJ   = 4,
    parameter int OBJ_W     = 40,
    parameter int OBJ_H     = 40,
    parameter int SCREEN_W  = 640,
    parameter int STEP      = 20,
    parameter int SPACING   = 160,
    parameter int FROG_SIDE = 40,
    parameter int X_TOL     = 5,
    parameter int Y_TOL     = 1
) (
    input  logic                   frame_clk,
    input  logic                   Reset,
    input  logic                   Enable,
    input  logic [10:0]            Lane_Y,
    input  logic [10:0]            Start_X,
    input  logic                   Direction,
    input  logic [5:0]             Speed,
    input  logic [10:0]            Frog_X,
    input  logic [10:0]            Frog_Y,
    output logic [NUM_OBJ*11-1:0]  Obj_X,
    output logic [NUM_OBJ-1:0]     Obj_Visible,
    output logic [NUM_OBJ-1:0]     Collision,
    output logic                   On_Object,
    output logic                   Step_Pulse,
    output logic [10:0]            Carry_Dx
`ifdef LANE_DIVE_EN
    ,
    output logic [1:0]             Dive_State
`endif
);

    import frogger_pkg::*;

    localparam int SPAN = SCREEN_W + OBJ_W;

    mover_state_t r_state, w_state_nxt;
    logic [5:0]   r_tick, w_tick_nxt;
    logic         w_step;
    coord_t       r_pos [NUM_OBJ];

    always_ff @(posedge frame_clk or posedge Reset) begin
        if (Reset) begin
            r_state <= WAIT;
            r_tick  <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_tick  <= w_tick_nxt;
        end
    end

    // Counter is compared before incrementing, so WAIT lasts Speed+1 frames
    // and the full step period is Speed+2 frames including MOVE.
    always_comb begin
        w_state_nxt = r_state;
        w_tick_nxt  = r_tick;
        w_step      = 1'b0;
        case (r_state)
            WAIT: begin
                if (Enable) begin
                    if (r_tick == Speed) begin
                        w_state_nxt = MOVE;
                        w_tick_nxt  = '0;
                    end else begin
                        w_tick_nxt  = r_tick + 6'd1;
                    end
                end
            end
            MOVE: begin
                w_step      = 1'b1;
                w_state_nxt = WAIT;
            end
            default: w_state_nxt = WAIT;
        endcase
    end

    assign Step_Pulse = w_step;

    // Positions update on the edge closing the MOVE frame; a reset during
    // MOVE therefore wins and no partial step is taken.
    always_ff @(posedge frame_clk or posedge Reset) begin
        if (Reset) begin
            for (int i = 0; i < NUM_OBJ; i++)
                r_pos[i] <= reset_pos(Start_X, i, OBJ_W, SPACING, SPAN);
        end else if (w_step) begin
            for (int i = 0; i < NUM_OBJ; i++)
                r_pos[i] <= step_pos(r_pos[i], Direction, coord_t'(STEP), coord_t'(SPAN));
        end
    end

`ifdef LANE_DIVE_EN
    dive_state_t r_dive, w_dive_nxt;
    logic [1:0]  r_dive_cnt, w_dive_cnt_nxt;

    always_ff @(posedge frame_clk or posedge Reset) begin
        if (Reset) begin
            r_dive     <= SURFACE;
            r_dive_cnt <= '0;
        end else begin
            r_dive     <= w_dive_nxt;
            r_dive_cnt <= w_dive_cnt_nxt;
        end
    end

    // Each phase lasts four steps; the phase encoding wraps RISING back to SURFACE.
    always_comb begin
        w_dive_nxt     = r_dive;
        w_dive_cnt_nxt = r_dive_cnt;
        if (w_step) begin
            if (r_dive_cnt == 2'd3) begin
                w_dive_cnt_nxt = '0;
                w_dive_nxt     = dive_state_t'(r_dive + 2'd1);
            end else begin
                w_dive_cnt_nxt = r_dive_cnt + 2'd1;
            end
        end
    end

    assign Dive_State = r_dive;

    for (genvar g = 0; g < NUM_OBJ; g++) begin : g_vis
        if (g % 2 == 1) begin : g_odd
            assign Obj_Visible[g] = (r_dive != SUBMERGED);
        end else begin : g_even
            assign Obj_Visible[g] = 1'b1;
        end
    end
`else
    assign Obj_Visible = '1;
`endif

    for (genvar g = 0; g < NUM_OBJ; g++) begin : g_obj
        assign Obj_X[11*g +: 11] = r_pos[g] - coord_t'(OBJ_W);

        lane_obj_collide #(
            .OBJ_W     (OBJ_W),
            .OBJ_H     (OBJ_H),
            .FROG_SIDE (FROG_SIDE),
            .X_TOL     (X_TOL),
            .Y_TOL     (Y_TOL)
        ) u_collide (
            .i_obj_x   (Obj_X[11*g +: 11]),
            .i_lane_y  (Lane_Y),
            .i_frog_x  (Frog_X),
            .i_frog_y  (Frog_Y),
            .i_visible (Obj_Visible[g]),
            .o_collide (Collision[g])
        );
    end

    assign On_Object = |Collision;
    assign Carry_Dx  = (Step_Pulse && On_Object) ?
                       (Direction ? 11'(STEP) : 11'(-STEP)) : 11'd0;

endmodule

// File: tb/tb_river_lane.sv
// tb/tb_river_lane.sv - scoreboard bench for river_lane (LANE_DIVE_EN adds dive scenario)
module tb_river_lane;

    localparam int NOBJ = 4;

    logic        frame_clk;
    logic        Reset, Enable, Direction;
    logic [10:0] Lane_Y, Start_X, Frog_X, Frog_Y;
    logic [5:0]  Speed;
    logic [43:0] Obj_X;
    logic [3:0]  Obj_Visible, Collision;
    logic        On_Object, Step_Pulse;
    logic [10:0] Carry_Dx;
`ifdef LANE_DIVE_EN
    logic [1:0]  Dive_State;
`endif

    river_lane #(.NUM_OBJ(NOBJ)) dut (
        .frame_clk   (frame_clk),
        .Reset       (Reset),
        .Enable      (Enable),
        .Lane_Y      (Lane_Y),
        .Start_X     (Start_X),
        .Direction   (Direction),
        .Speed       (Speed),
        .Frog_X      (Frog_X),
        .Frog_Y      (Frog_Y),
        .Obj_X       (Obj_X),
        .Obj_Visible (Obj_Visible),
        .Collision   (Collision),
        .On_Object   (On_Object),
        .Step_Pulse  (Step_Pulse),
        .Carry_Dx    (Carry_Dx)
`ifdef LANE_DIVE_EN
        ,
        .Dive_State  (Dive_State)
`endif
    );

    initial frame_clk = 1'b0;
    always #5 frame_clk = ~frame_clk;

    typedef struct packed {
        logic [1:0]  dive;
        logic [43:0] objx;
        logic [3:0]  vis;
        logic [3:0]  col;
        logic        on;
        logic        sp;
        logic [10:0] carry;
    } frame_t;

    frame_t sb_q[$];
    int n_pass  = 0;
    int n_total = 0;

    // Reference model state
    int m_pos[NOBJ];
    int m_cnt, m_dive, m_dcnt;
    bit m_move;

    function automatic frame_t model_frame();
        frame_t e;
        int ox, xl, xr, yt, yb, ly;
        logic hx, hy;
        logic [10:0] t;
        e  = '0;
        xl = int'(Frog_X) + 5;
        xr = int'(Frog_X) + 35;
        yt = int'(Frog_Y) + 1;
        yb = int'(Frog_Y) + 39;
        ly = int'(Lane_Y);
        for (int i = 0; i < NOBJ; i++) begin
            ox = m_pos[i] - 40;
            t  = ox[10:0];
            e.objx[i*11 +: 11] = t;
            e.vis[i] = 1'b1;
`ifdef LANE_DIVE_EN
            if ((i % 2 == 1) && (m_dive == 2)) e.vis[i] = 1'b0;
`endif
            hx = ((xl >= ox) && (xl <= ox + 40)) || ((xr >= ox) && (xr <= ox + 40));
            hy = ((yt >= ly) && (yt <= ly + 40)) || ((yb >= ly) && (yb <= ly + 40));
            e.col[i] = e.vis[i] & hx & hy;
        end
        e.on = |e.col;
        e.sp = m_move;
        if (e.sp && e.on) e.carry = Direction ? 11'd20 : 11'h7EC;
`ifdef LANE_DIVE_EN
        e.dive = 2'(m_dive);
`endif
        return e;
    endfunction

    task automatic model_edge();
        if (m_move) begin
            for (int i = 0; i < NOBJ; i++)
                m_pos[i] = Direction ? (m_pos[i] + 20) % 680 : (m_pos[i] + 660) % 680;
            m_move = 0;
            m_dcnt = m_dcnt + 1;
            if (m_dcnt == 4) begin
                m_dcnt = 0;
                m_dive = (m_dive + 1) % 4;
            end
        end else if (Enable) begin
            if (m_cnt == int'(Speed)) begin
                m_move = 1;
                m_cnt  = 0;
            end else begin
                m_cnt = (m_cnt + 1) % 64;
            end
        end
    endtask

    // Called at a negedge with inputs already driven.
    task automatic frame(output frame_t got);
        #1;
        got.objx  = Obj_X;
        got.vis   = Obj_Visible;
        got.col   = Collision;
        got.on    = On_Object;
        got.sp    = Step_Pulse;
        got.carry = Carry_Dx;
`ifdef LANE_DIVE_EN
        got.dive  = Dive_State;
`else
        got.dive  = 2'd0;
`endif
        sb_q.push_back(model_frame());
        model_edge();
        @(negedge frame_clk);
    endtask

    task automatic model_reset(input int start);
        for (int i = 0; i < NOBJ; i++) m_pos[i] = (start + 40 + i * 160) % 680;
        m_cnt = 0; m_move = 0; m_dive = 0; m_dcnt = 0;
    endtask

    task automatic apply_reset(input int start);
        Reset   = 1'b1;
        Start_X = 11'(start);
        model_reset(start);
        @(negedge frame_clk);
        Reset = 1'b0;
    endtask

    task automatic test_reset();
        frame_t got, exp;
        Enable = 1'b1; Direction = 1'b1; Speed = 6'd3;
        Lane_Y = 11'd100; Frog_X = 11'd0; Frog_Y = 11'd300;
        Reset = 1'b1; Start_X = 11'd0;
        model_reset(0);
        #1;
        n_total++;
        if (Obj_X !== {11'd480, 11'd320, 11'd160, 11'd0})
            $display("FAIL reset_obj_x: got %h exp %h", Obj_X, {11'd480, 11'd320, 11'd160, 11'd0});
        else n_pass++;
        n_total++;
        if ({Step_Pulse, Carry_Dx, Obj_Visible, Collision} !== {1'b0, 11'd0, 4'hF, 4'h0})
            $display("FAIL reset_flags: got sp=%b carry=%h vis=%h col=%h exp 0/000/f/0",
                     Step_Pulse, Carry_Dx, Obj_Visible, Collision);
        else n_pass++;
        @(negedge frame_clk);
        Reset = 1'b0;
        frame(got);
        exp = sb_q.pop_front();
        n_total++;
        if (got !== exp) $display("FAIL reset_first_frame: got %h exp %h", got, exp);
        else n_pass++;
    endtask

    task automatic test_step_right();
        frame_t got, exp;
        int pulses[$];
        Speed = 6'd3; Direction = 1'b1; Enable = 1'b1; Frog_Y = 11'd300;
        apply_reset(0);
        for (int f = 0; f < 22; f++) begin
            frame(got);
            exp = sb_q.pop_front();
            n_total++;
            if (got !== exp) $display("FAIL step_right f%0d: got %h exp %h", f, got, exp);
            else n_pass++;
            if (got.sp) pulses.push_back(f);
            if (f == 5) begin
                n_total++;
                if (got.objx !== {11'd500, 11'd340, 11'd180, 11'd20})
                    $display("FAIL step_right_first: got %h exp %h", got.objx,
                             {11'd500, 11'd340, 11'd180, 11'd20});
                else n_pass++;
            end
        end
        n_total++;
        if (pulses.size() != 4 || pulses[0] != 4 || pulses[3] - pulses[0] != 15)
            $display("FAIL step_right_period: got %0d pulses first=%0d exp 4 pulses first=4 period 5",
                     pulses.size(), (pulses.size() > 0) ? pulses[0] : -1);
        else n_pass++;
    endtask

    task automatic test_wrap_right();
        frame_t got, exp;
        int d;
        Speed = 6'd0; Direction = 1'b1; Enable = 1'b1; Frog_Y = 11'd300;
        apply_reset(600);
        for (int f = 0; f < 6; f++) begin
            frame(got);
            exp = sb_q.pop_front();
            n_total++;
            if (got !== exp) $display("FAIL wrap_right f%0d: got %h exp %h", f, got, exp);
            else n_pass++;
            if (f == 4) begin
                d = ($signed(got.objx[21:11]) - $signed(got.objx[10:0]) + 680) % 680;
                n_total++;
                if (got.objx[10:0] !== 11'h7D8 || d != 160)
                    $display("FAIL wrap_right_edge: got x0=%h gap=%0d exp x0=7d8 gap=160",
                             got.objx[10:0], d);
                else n_pass++;
            end
        end
    endtask

    task automatic test_wrap_left();
        frame_t got, exp;
        Speed = 6'd0; Direction = 1'b0; Enable = 1'b1; Frog_Y = 11'd300;
        apply_reset(0);
        for (int f = 0; f < 8; f++) begin
            frame(got);
            exp = sb_q.pop_front();
            n_total++;
            if (got !== exp) $display("FAIL wrap_left f%0d: got %h exp %h", f, got, exp);
            else n_pass++;
            if (f == 4 || f == 6) begin
                n_total++;
                if (got.objx[10:0] !== ((f == 4) ? 11'h7D8 : 11'd620))
                    $display("FAIL wrap_left_edge f%0d: got %h exp %h", f, got.objx[10:0],
                             (f == 4) ? 11'h7D8 : 11'd620);
                else n_pass++;
            end
        end
    endtask

    task automatic test_enable_hold();
        frame_t got, exp;
        int first;
        Speed = 6'd3; Direction = 1'b1; Enable = 1'b1; Frog_Y = 11'd300;
        apply_reset(0);
        for (int f = 0; f < 14; f++) begin
            Enable = (f >= 2 && f < 12) ? 1'b0 : 1'b1;
            frame(got);
            exp = sb_q.pop_front();
            n_total++;
            if (got !== exp) $display("FAIL enable_hold f%0d: got %h exp %h", f, got, exp);
            else n_pass++;
            if (f >= 2 && f < 12 && (got.sp || got.objx !== {11'd480, 11'd320, 11'd160, 11'd0})) begin
                n_total++;
                $display("FAIL enable_frozen f%0d: got sp=%b x=%h exp sp=0 x unchanged", f, got.sp, got.objx);
            end
        end
        first = -1;
        for (int f = 0; f < 4; f++) begin
            frame(got);
            exp = sb_q.pop_front();
            n_total++;
            if (got !== exp) $display("FAIL enable_resume f%0d: got %h exp %h", f, got, exp);
            else n_pass++;
            if (got.sp && first < 0) first = f;
        end
        // Held count was 2 at freeze: two WAIT frames remained (12,13), so MOVE is frame 0 here.
        n_total++;
        if (first != 0) $display("FAIL enable_resume_pulse: got frame %0d exp 0", first);
        else n_pass++;
    endtask

    task automatic test_collision();
        frame_t got, exp;
        Speed = 6'd1; Direction = 1'b1; Enable = 1'b1; Lane_Y = 11'd100;
        apply_reset(0);
        for (int f = 0; f < 12; f++) begin
            Direction = (f < 6) ? 1'b1 : 1'b0;
            Frog_X = 11'(m_pos[0] - 40 + 10);
            Frog_Y = 11'd100;
            if (f == 2)  Frog_X = 11'(m_pos[0]);
            if (f == 3)  Frog_Y = 11'd140;
            if (f == 4)  Frog_Y = 11'd139;
            frame(got);
            exp = sb_q.pop_front();
            n_total++;
            if (got !== exp) $display("FAIL collision f%0d: got %h exp %h", f, got, exp);
            else n_pass++;
            if (got.sp && f != 2 && f != 3) begin
                n_total++;
                if (got.carry !== (Direction ? 11'd20 : 11'h7EC) || got.col[0] !== 1'b1)
                    $display("FAIL carry f%0d: got carry=%h col=%b exp %h col=1", f, got.carry,
                             got.col[0], Direction ? 11'd20 : 11'h7EC);
                else n_pass++;
            end
            if (f == 2 || f == 3) begin
                n_total++;
                if (got.col !== 4'h0 || got.on !== 1'b0)
                    $display("FAIL no_collision_edge f%0d: got col=%h on=%b exp 0", f, got.col, got.on);
                else n_pass++;
            end
        end
    endtask

    task automatic test_back_to_back();
        frame_t got, exp;
        int np;
        Speed = 6'd0; Direction = 1'b1; Enable = 1'b1; Frog_Y = 11'd300;
        apply_reset(40);
        np = 0;
        for (int f = 0; f < 10; f++) begin
            if (f == 5) Direction = 1'b0;
            frame(got);
            exp = sb_q.pop_front();
            n_total++;
            if (got !== exp) $display("FAIL back_to_back f%0d: got %h exp %h", f, got, exp);
            else n_pass++;
            if (got.sp) np++;
        end
        n_total++;
        if (np != 5) $display("FAIL back_to_back_count: got %0d exp 5", np);
        else n_pass++;
    endtask

    task automatic test_reset_mid_move();
        frame_t got, exp;
        Speed = 6'd1; Direction = 1'b1; Enable = 1'b1; Frog_Y = 11'd300;
        apply_reset(0);
        for (int f = 0; f < 10 && !m_move; f++) begin
            frame(got);
            exp = sb_q.pop_front();
            n_total++;
            if (got !== exp) $display("FAIL mid_move_pre f%0d: got %h exp %h", f, got, exp);
            else n_pass++;
        end
        n_total++;
        if (!m_move) $display("FAIL mid_move_reach: got no MOVE frame exp one within 10");
        else n_pass++;
        Reset = 1'b1;
        model_reset(0);
        #1;
        n_total++;
        if (Step_Pulse !== 1'b0) $display("FAIL mid_move_pulse: got %b exp 0", Step_Pulse);
        else n_pass++;
        @(negedge frame_clk);
        Reset = 1'b0;
        frame(got);
        exp = sb_q.pop_front();
        n_total++;
        if (got !== exp || got.objx !== {11'd480, 11'd320, 11'd160, 11'd0})
            $display("FAIL mid_move_pos: got %h exp %h", got, exp);
        else n_pass++;
    endtask

`ifdef LANE_DIVE_EN
    task automatic test_dive();
        frame_t got, exp;
        Speed = 6'd0; Direction = 1'b1; Enable = 1'b1; Lane_Y = 11'd100;
        apply_reset(0);
        for (int f = 0; f < 26; f++) begin
            Frog_X = 11'(m_pos[1] - 40 + 10);
            Frog_Y = 11'd100;
            frame(got);
            exp = sb_q.pop_front();
            n_total++;
            if (got !== exp) $display("FAIL dive f%0d: got %h exp %h", f, got, exp);
            else n_pass++;
            if (f == 16 || f == 24) begin
                n_total++;
                if (got.vis !== ((f == 16) ? 4'b0101 : 4'b1111) || got.col[1] !== (f == 24))
                    $display("FAIL dive_phase f%0d: got vis=%b col1=%b dive=%0d", f, got.vis,
                             got.col[1], got.dive);
                else n_pass++;
            end
        end
    endtask
`endif

    initial begin
        test_reset();
        test_step_right();
        test_wrap_right();
        test_wrap_left();
        test_enable_hold();
        test_collision();
        test_back_to_back();
        test_reset_mid_move();
`ifdef LANE_DIVE_EN
        test_dive();
`endif
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
